multi_debouncer: RTL and testbench
==================================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The module SHALL have parameter W, default 4, giving the number of independent input channels (W >= 1).
REQ-002 The module SHALL have parameter DELAY, default 50000, giving the number of consecutive cycles of disagreement needed before a channel's output changes (DELAY >= 1).
REQ-003 The module SHALL have parameter DETECT, default 1, selecting which edges produce pulses: 0 = falling, 1 = rising, 2 = both.
REQ-004 The module SHALL have parameter MODE, default 1, selecting pulse polarity: 1 = output idle 0 with a positive pulse, 0 = output idle 1 with a negative pulse.
REQ-005 The module SHALL have parameter SYNC, default 1: 1 = each input passes a 2-flop synchronizer, 0 = inputs are used directly.
REQ-006 The module SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port x, input, W bits: raw, noisy, possibly asynchronous inputs, one bit per channel.
REQ-009 The module SHALL have port z, output, W bits: registered debounced level per channel.
REQ-010 The module SHALL have port p, output, W bits: registered edge-pulse per channel.

Function
REQ-011 Channels SHALL be fully independent; no channel's state affects another's.
REQ-012 Per channel, the filtered sample s SHALL be the second synchronizer flop output when SYNC=1, and x[i] when SYNC=0.
REQ-013 Per channel, a counter of width $clog2(DELAY+1) SHALL be kept, with these rules at each edge:
  - s == z[i]: counter <= 0.
  - s != z[i] and counter == DELAY-1: z[i] <= s, counter <= 0.
  - otherwise: counter <= counter+1.
REQ-014 A level held on x[i] SHALL appear on z[i] at the (2*SYNC + DELAY)-th rising edge, counting the first edge that samples the new level as edge 1.
REQ-015 Any return of s to z[i] before the counter reaches DELAY-1 SHALL discard the count; z[i] SHALL NOT change, so pulses shorter than DELAY cycles are rejected.
REQ-016 The counter SHALL never exceed DELAY-1 and SHALL never wrap.
REQ-017 p[i] SHALL be active (1 if MODE=1, 0 if MODE=0) for exactly one cycle: the cycle in which z[i] first shows a new value matching DETECT. At all other times p[i] SHALL hold its idle value.
REQ-018 With DETECT=2, every change of z[i] SHALL produce exactly one pulse.
REQ-019 Edges on several channels in the same cycle SHALL produce pulses on all of those channels in that same cycle.
REQ-020 z and p SHALL be driven only from flops, with no combinational path from x.

Reset
REQ-021 When reset=1 at a rising edge, the following SHALL be cleared on that edge, for all channels and regardless of x or in-progress counts:
  - z to 0;
  - all counters to 0;
  - synchronizer flops to 0;
  - p to its idle value ({W{~MODE}}).
REQ-022 Reset SHALL take priority over all other updates.
REQ-023 After reset releases, operation SHALL restart from z=0 with no pulse generated by the reset itself.
REQ-024 A channel whose x is 1 during reset SHALL leave reset at z=0 and then follow REQ-013/014 normally, producing a rising pulse if DETECT allows.

Verification
REQ-025 Scenario, clean press: W=4, DELAY=5, SYNC=1, DETECT=1, MODE=1; x[0] 0->1, held 20 cycles -> z[0] rises at edge 7 after the change; p[0]=1 for that cycle only; z[3:1] and p[3:1] stay 0.
REQ-026 Scenario, glitch reject: same parameters; x[1] high for 4 cycles, then a 1-cycle pulse, then high 3 cycles -> z[1] stays 0 and p[1] stays 0 throughout.
REQ-027 Scenario, release with DETECT=2, MODE=0: after z[2]=1 is established, x[2] 1->0 held 10 cycles -> z[2] falls at edge 7; p[2]=0 for exactly one cycle on both the earlier rise and this fall, 1 otherwise.
REQ-028 Scenario, simultaneous edges: x=4'b1111 applied in one cycle, held 10 cycles -> z=4'b1111 and p=4'b1111 in the same single cycle.
REQ-029 Scenario, reset mid-count: x[0]=1 held; reset pulsed for 1 cycle at edge 4 after the change -> z[0]=0 through that edge, and z[0] then rises 7 edges after reset deasserts, with one pulse.
REQ-030 Scenario, SYNC=0 and DELAY=1: x[0] toggles once and holds -> z[0] follows at the first sampling edge, and p[0] pulses that cycle.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: optional 2-flop synchronizer, per-channel disagreement
// counter, registered debounced level (z) and registered edge pulse (p).
module multi_debouncer #(
    parameter int W      = 4,
    parameter int DELAY  = 50000,
    parameter int DETECT = 1,
    parameter int MODE   = 1,
    parameter int SYNC   = 1
) (
    input  logic         ck,
    input  logic         reset,
    input  logic [W-1:0] x,
    output logic [W-1:0] z,
    output logic [W-1:0] p
);
    localparam int            CW      = $clog2(DELAY + 1);
    localparam logic [CW-1:0] LAST    = CW'(DELAY - 1);
    localparam logic          IDLE    = (MODE == 0);
    localparam logic          ON_RISE = (DETECT == 1) || (DETECT == 2);
    localparam logic          ON_FALL = (DETECT == 0) || (DETECT == 2);

    logic [W-1:0] s;

    generate
        if (SYNC != 0) begin : g_sync
            logic [W-1:0] s1;
            logic [W-1:0] s2;
            always_ff @(posedge ck) begin
                if (reset) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= x;
                    s2 <= s1;
                end
            end
            assign s = s2;
        end else begin : g_direct
            assign s = x;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_ch
            logic [CW-1:0] cnt;
            logic          z_r;
            logic          p_r;

            // Count runs of disagreement; any agreement discards the run.
            always_ff @(posedge ck) begin
                if (reset) begin
                    cnt <= '0;
                    z_r <= 1'b0;
                    p_r <= IDLE;
                end else begin
                    p_r <= IDLE;
                    if (s[gi] == z_r) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        z_r <= s[gi];
                        if ((s[gi] && ON_RISE) || (!s[gi] && ON_FALL))
                            p_r <= ~IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            assign z[gi] = z_r;
            assign p[gi] = p_r;
        end
    endgenerate
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: three configurations share one stimulus stream and
// are checked every cycle against a sliding-window model, plus pinned scenarios.
module tb_multi_debouncer;
    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] x = 4'b0000;
    logic [3:0] z_a, p_a, z_b, p_b, z_c, p_c;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 ck = ~ck;

    multi_debouncer #(.W(4), .DELAY(5), .DETECT(1), .MODE(1), .SYNC(1)) dut_a (
        .ck(ck), .reset(reset), .x(x), .z(z_a), .p(p_a));
    multi_debouncer #(.W(4), .DELAY(5), .DETECT(2), .MODE(0), .SYNC(1)) dut_b (
        .ck(ck), .reset(reset), .x(x), .z(z_b), .p(p_b));
    multi_debouncer #(.W(4), .DELAY(1), .DETECT(2), .MODE(1), .SYNC(0)) dut_c (
        .ck(ck), .reset(reset), .x(x), .z(z_c), .p(p_c));

    // Model: z flips once the last DELAY samples all disagree with it.
    int   cd[3]   = '{5, 5, 1};
    int   cs[3]   = '{1, 1, 0};
    int   cdet[3] = '{1, 2, 2};
    int   cm[3]   = '{1, 0, 1};
    bit   m1[3][4];
    bit   m2[3][4];
    bit   hist[3][4][5];
    logic [3:0] mz[3];
    logic [3:0] mp[3];
    bit   sv;
    bit   all_dis;

    always @(posedge ck) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    m1[k][i] = 1'b0;
                    m2[k][i] = 1'b0;
                    for (int j = 0; j < 5; j++) hist[k][i][j] = 1'b0;
                    mz[k][i] = 1'b0;
                    mp[k][i] = (cm[k] == 0);
                end else begin
                    sv = (cs[k] != 0) ? m2[k][i] : x[i];
                    m2[k][i] = m1[k][i];
                    m1[k][i] = x[i];
                    for (int j = 4; j > 0; j--) hist[k][i][j] = hist[k][i][j-1];
                    hist[k][i][0] = sv;
                    all_dis = 1'b1;
                    for (int j = 0; j < cd[k]; j++)
                        if (hist[k][i][j] == mz[k][i]) all_dis = 1'b0;
                    mp[k][i] = (cm[k] == 0);
                    if (all_dis) begin
                        mz[k][i] = ~mz[k][i];
                        if (cdet[k] == 2 || cdet[k] == int'(mz[k][i]))
                            mp[k][i] = (cm[k] != 0);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ck) begin
        if (chk_en) begin
            chk("model_z_a", z_a, mz[0]);
            chk("model_p_a", p_a, mp[0]);
            chk("model_z_b", z_b, mz[1]);
            chk("model_p_b", p_b, mp[1]);
            chk("model_z_c", z_c, mz[2]);
            chk("model_p_c", p_c, mp[2]);
        end
    end

    logic [3:0] glitch[18] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001,
                               4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001};
    int rate;
    int len;

    initial begin
        reset = 1'b1;
        x = 4'b0000;
        repeat (2) @(negedge ck);
        chk_en = 1'b1;
        chk("reset_z_a", z_a, 4'b0000);
        chk("reset_p_a", p_a, 4'b0000);
        chk("reset_p_b", p_b, 4'b1111);
        reset = 1'b0;
        repeat (3) @(negedge ck);

        // Clean press on channel 0.
        x = 4'b0001;
        for (int e = 1; e <= 20; e++) begin
            @(negedge ck);
            if (e == 1) begin
                chk("c_follow_z", z_c, 4'b0001);
                chk("c_follow_p", p_c, 4'b0001);
            end
            if (e == 2) chk("c_pulse_end", p_c, 4'b0000);
            if (e == 6) chk("press_pre_z", z_a, 4'b0000);
            if (e == 7) begin
                chk("press_z", z_a, 4'b0001);
                chk("press_p", p_a, 4'b0001);
                chk("press_p_b", p_b, 4'b1110);
            end
            if (e == 8) begin
                chk("press_p_end", p_a, 4'b0000);
                chk("press_p_b_end", p_b, 4'b1111);
            end
        end

        // Glitch on channel 1 never reaches DELAY consecutive samples.
        for (int e = 0; e < 18; e++) begin
            x = glitch[e];
            @(negedge ck);
            chk("glitch_z", z_a, 4'b0001);
            chk("glitch_p", p_a, 4'b0000);
        end

        // Channel 2 rise then fall on the both-edge, active-low config.
        x = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            @(negedge ck);
            if (e == 6) chk("b_rise_pre", z_b, 4'b0001);
            if (e == 7) begin
                chk("b_rise_z", z_b, 4'b0101);
                chk("b_rise_p", p_b, 4'b1011);
            end
            if (e == 8) chk("b_rise_p_end", p_b, 4'b1111);
        end
        x = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            @(negedge ck);
            if (e == 6) chk("b_fall_pre", z_b, 4'b0101);
            if (e == 7) begin
                chk("b_fall_z", z_b, 4'b0001);
                chk("b_fall_p", p_b, 4'b1011);
            end
            if (e == 8) chk("b_fall_p_end", p_b, 4'b1111);
        end

        // All channels rise together.
        x = 4'b0000;
        repeat (10) @(negedge ck);
        x = 4'b1111;
        for (int e = 1; e <= 10; e++) begin
            @(negedge ck);
            if (e == 6) chk("simul_pre", z_a, 4'b0000);
            if (e == 7) begin
                chk("simul_z", z_a, 4'b1111);
                chk("simul_p", p_a, 4'b1111);
            end
            if (e == 8) chk("simul_p_end", p_a, 4'b0000);
        end

        // Reset in the middle of a count restarts the whole sequence.
        x = 4'b0000;
        repeat (10) @(negedge ck);
        x = 4'b0001;
        for (int e = 1; e <= 3; e++) begin
            @(negedge ck);
            chk("rst_mid_z", z_a, 4'b0000);
        end
        reset = 1'b1;
        @(negedge ck);
        chk("rst_edge_z", z_a, 4'b0000);
        chk("rst_edge_p", p_a, 4'b0000);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge ck);
            if (e == 6) chk("rst_after_pre", z_a, 4'b0000);
            if (e == 7) begin
                chk("rst_after_z", z_a, 4'b0001);
                chk("rst_after_p", p_a, 4'b0001);
            end
            if (e == 8) chk("rst_after_p_end", p_a, 4'b0000);
        end

        // Random segments with differing toggle rates and rare resets.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 2))
                0:       rate = 2;
                1:       rate = 8;
                default: rate = 40;
            endcase
            len = $urandom_range(20, 80);
            repeat (len) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, rate - 1) == 0) x[i] = ~x[i];
                reset = ($urandom_range(0, 299) == 0);
                @(negedge ck);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge ck);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
